bram_readback_misr: RTL and testbench
=====================================

Name: bram_readback_misr

Overview:
- Downstream consumer of the initialised 2K-deep block RAM.
- On a start pulse, sweeps the RAM read port from address 0 to DEPTH_MEM-1 and compresses every dout word into a 32-bit MISR signature.
- Compares the signature against an expected value, so firmware and the bench can confirm that a bitstream memory re-init landed the intended contents.
- Drives raddr only; the RAM write side belongs to other logic.

Parameters:
- WID_MEM, 18, RAM data width (1..32).
- DEPTH_MEM, 2048, number of words swept (1..2048; need not be a power of 2).
- AW, 11, RAM address width.
- SIG_W, 32, signature width (fixed 32 in this revision).
- SEED, 32'h0000_0000, signature value loaded at the start of a sweep.

Ports:
- clk  in  1  Clock.
- reset  in  1  Reset; synchronous, active-low.
- start  in  1  One-cycle sweep request; sampled in IDLE or DONE only.
- expected_sig  in  32  Golden signature; sampled at the DONE transition.
- raddr  out  AW  Read address to the RAM.
- dout  in  WID_MEM  RAM read data; one-cycle latency after raddr.
- busy  out  1  High in SWEEP and DRAIN.
- done  out  1  High in DONE; held until the next start or reset.
- pass  out  1  Valid only while done: signature == expected_sig.
- signature  out  32  Accumulated MISR value; frozen in DONE.
- word_count  out  AW+1  Number of words absorbed.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a clk edge): state IDLE; raddr=0, busy=0, done=0, pass=0, signature=SEED, word_count=0.
- Reset asserted mid-sweep aborts immediately to these values. No partial result is kept.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE -> SWEEP on start.
  - raddr=0, signature=SEED, word_count=0.
  - done and pass drop in the same edge.
- SWEEP:
  - raddr increments by 1 each cycle.
  - At raddr==DEPTH_MEM-1 go to DRAIN and hold raddr; never wrap past DEPTH_MEM-1.
- DRAIN: one cycle to absorb the last word -> DONE.
- start seen in SWEEP or DRAIN is ignored (no queueing, no restart).
- Timing, with start high in cycle t:
  - raddr=k in cycle t+1+k.
  - Matching dout is absorbed at the end of cycle t+2+k.
  - done=1 from cycle t+2+DEPTH_MEM.
  - busy=1 for cycles t+1 .. t+1+DEPTH_MEM.
- Absorb valid flag:
  - A 1-cycle delayed copy of "address issued", set in every SWEEP cycle.
  - The DRAIN cycle absorbs the final word.
  - The first SWEEP cycle absorbs nothing.
- MISR step, per absorbed word d zero-extended to 32 bits:
  - sig_n = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ d.
  - POLY = 32'h04C1_1DB7.
- word_count increments on each absorb and equals DEPTH_MEM in DONE.
- pass is registered on entry to DONE, using the final signature and expected_sig sampled that cycle.
- DEPTH_MEM==1: SWEEP lasts one cycle, done at t+3.

Decomposition:
- Package bram_check_pkg:
  - state enum typedef (IDLE, SWEEP, DRAIN, DONE).
  - POLY constant.
  - SIG_W localparam.
  - Function misr_next(sig, data).
- One sub-module, misr_accum:
  - Holds the signature register.
  - Ports: clk, reset, clear, en, data, sig.
- Top holds the FSM, the address counter, the valid delay, word_count and the compare.

Test Plan:
- DEPTH_MEM=4, SEED=0, RAM all zeros, start at t=10 -> raddr 0,1,2,3 in cycles 11-14; done=1 at cycle 16; signature=0; word_count=4; pass=1 with expected_sig=0.
- DEPTH_MEM=4, word[0]=18'h1, others 0 -> signature=32'h8. Word[3]=1 only -> signature=32'h1. expected_sig=32'h9 -> pass=0.
- DEPTH_MEM=2048, 2kb18 init contents -> signature matches the software MISR model; pass=1; done exactly 2050 cycles after start.
- start pulsed again in cycle t+5 of a DEPTH_MEM=4 sweep -> ignored; done still at t+6; a later start from DONE clears done and restarts at raddr=0.
- reset low at cycle t+3 mid-sweep -> next edge: raddr=0, busy=0, done=0, signature=SEED, word_count=0; no done ever for that sweep.
- DEPTH_MEM=1, word[0]=18'h3FFFF -> done at t+3; signature=32'h0003_FFFF; word_count=1.

Source files
------------

// File: rtl/bram_check_pkg.sv
// Shared types and the MISR step used by the BRAM readback checker.
package bram_check_pkg;

    localparam int          SIG_W = 32;
    localparam logic [31:0] POLY  = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One signature step: shift left, fold the CRC-32 polynomial on carry-out, xor in the data.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                   input logic [SIG_W-1:0] data);
        misr_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ data;
    endfunction

endpackage

// File: rtl/bram_readback_misr_if.sv
// Control, status and RAM read-port bundle of the readback checker.
interface bram_readback_misr_if #(
    parameter int AW      = 11,
    parameter int WID_MEM = 18
);
    logic               start;
    logic [31:0]        expected_sig;
    logic [AW-1:0]      raddr;
    logic [WID_MEM-1:0] dout;
    logic               busy;
    logic               done;
    logic               pass;
    logic [31:0]        signature;
    logic [AW:0]        word_count;

    modport master (
        input  start, expected_sig, dout,
        output raddr, busy, done, pass, signature, word_count
    );

    modport slave (
        output start, expected_sig, dout,
        input  raddr, busy, done, pass, signature, word_count
    );
endinterface

// File: rtl/misr_accum.sv
// Signature register: reloads SEED on clear, takes one MISR step per enabled cycle.
module misr_accum
    import bram_check_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    // Clear has priority so a restart never mixes in a word from the previous sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sig <= SEED;
        end else if (clear) begin
            sig <= SEED;
        end else if (en) begin
            sig <= misr_next(sig, data);
        end
    end

endmodule

// File: rtl/bram_readback_misr.sv
// Sweeps the RAM read port once per start and compresses every word into a MISR signature.
//
// state | meaning
// IDLE  | waiting for start after reset
// SWEEP | issuing read addresses 0..DEPTH_MEM-1
// DRAIN | absorbing the last word still in the RAM output register
// DONE  | signature frozen, pass valid, waiting for the next start
module bram_readback_misr #(
    parameter int          WID_MEM   = 18,
    parameter int          DEPTH_MEM = 2048,
    parameter int          AW        = 11,
    parameter int          SIG_W     = 32,
    parameter logic [31:0] SEED      = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    bram_readback_misr_if.master bus
);
    import bram_check_pkg::*;

    state_t             state;
    state_t             state_n;
    logic [AW-1:0]      raddr;
    logic               vld;
    logic [AW:0]        word_count;
    logic               pass;
    logic [SIG_W-1:0]   sig;
    logic [SIG_W-1:0]   data_ext;
    logic [WID_MEM-1:0] rdata;
    logic               start_ok;
    logic               last_addr;

    assign rdata     = bus.dout;
    assign data_ext  = SIG_W'(rdata);
    assign start_ok  = bus.start && ((state == IDLE) || (state == DONE));
    assign last_addr = (raddr == AW'(DEPTH_MEM - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; start is only honoured when no sweep is in flight.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = SWEEP;
            SWEEP:   if (last_addr) state_n = DRAIN;
            DRAIN:   state_n = DONE;
            DONE:    if (bus.start) state_n = SWEEP;
            default: state_n = IDLE;
        endcase
    end

    // Address counter, absorb-valid delay, word counter and the final compare.
    always_ff @(posedge clk) begin
        if (!reset) begin
            raddr      <= '0;
            vld        <= 1'b0;
            word_count <= '0;
            pass       <= 1'b0;
        end else begin
            // dout lags raddr by one cycle, so every SWEEP cycle yields a word one cycle later.
            vld <= (state == SWEEP);
            if (start_ok) begin
                raddr      <= '0;
                word_count <= '0;
                pass       <= 1'b0;
            end else begin
                if ((state == SWEEP) && !last_addr) begin
                    raddr <= raddr + 1'b1;
                end
                if (vld) begin
                    word_count <= word_count + 1'b1;
                end
                // The last word lands in the signature on this same edge, so compare the stepped value.
                if (state == DRAIN) begin
                    pass <= (misr_next(sig, data_ext) == bus.expected_sig);
                end
            end
        end
    end

    misr_accum #(
        .SEED (SEED)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .en    (vld),
        .data  (data_ext),
        .sig   (sig)
    );

    assign bus.raddr      = raddr;
    assign bus.busy       = (state == SWEEP) || (state == DRAIN);
    assign bus.done       = (state == DONE);
    assign bus.pass       = pass;
    assign bus.signature  = sig;
    assign bus.word_count = word_count;

endmodule

// File: tb/tb_bram_readback_misr.sv
// Bench for bram_readback_misr: three depths (4, 2048, 1) sharing clock and reset.
module tb_bram_readback_misr;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_readback_misr_if #(.AW(11), .WID_MEM(18)) if4 ();
    bram_readback_misr_if #(.AW(11), .WID_MEM(18)) if2k ();
    bram_readback_misr_if #(.AW(11), .WID_MEM(18)) if1 ();

    bram_readback_misr #(.WID_MEM(18), .DEPTH_MEM(4), .AW(11), .SIG_W(32), .SEED(32'h0))
        u_d4 (.clk(clk), .reset(reset), .bus(if4));
    bram_readback_misr #(.WID_MEM(18), .DEPTH_MEM(2048), .AW(11), .SIG_W(32), .SEED(32'h0))
        u_d2k (.clk(clk), .reset(reset), .bus(if2k));
    bram_readback_misr #(.WID_MEM(18), .DEPTH_MEM(1), .AW(11), .SIG_W(32), .SEED(32'h0))
        u_d1 (.clk(clk), .reset(reset), .bus(if1));

    logic [17:0] mem4 [4];
    logic [17:0] mem2k [2048];
    logic [17:0] mem1;

    // Read-port models with one cycle of latency.
    always @(posedge clk) begin
        if4.dout  <= mem4[if4.raddr[1:0]];
        if2k.dout <= mem2k[if2k.raddr];
        if1.dout  <= mem1;
    end

    typedef struct {
        string       name;
        logic [31:0] sig;
        logic        pass;
        int          wc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [3:0][17:0] w;
        logic [31:0]      exp_in;
        logic [31:0]      sig;
        logic             pass;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] d);
        logic fb;
        fb = s[31];
        s = s << 1;
        if (fb) s = s ^ 32'h04C11DB7;
        return s ^ d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // what: 0 raddr, 1 busy, 2 done, 3 pass, 4 signature, 5 word_count
    function automatic logic [31:0] probe(input int sel, input int what);
        logic [31:0] r;
        r = '0;
        case (sel)
            0: case (what)
                   0: r = 32'(if4.raddr);
                   1: r = 32'(if4.busy);
                   2: r = 32'(if4.done);
                   3: r = 32'(if4.pass);
                   4: r = if4.signature;
                   default: r = 32'(if4.word_count);
               endcase
            1: case (what)
                   0: r = 32'(if2k.raddr);
                   1: r = 32'(if2k.busy);
                   2: r = 32'(if2k.done);
                   3: r = 32'(if2k.pass);
                   4: r = if2k.signature;
                   default: r = 32'(if2k.word_count);
               endcase
            default: case (what)
                   0: r = 32'(if1.raddr);
                   1: r = 32'(if1.busy);
                   2: r = 32'(if1.done);
                   3: r = 32'(if1.pass);
                   4: r = if1.signature;
                   default: r = 32'(if1.word_count);
               endcase
        endcase
        return r;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [31:0] exp_in);
        case (sel)
            0: begin if4.start = st;  if4.expected_sig = exp_in;  end
            1: begin if2k.start = st; if2k.expected_sig = exp_in; end
            default: begin if1.start = st; if1.expected_sig = exp_in; end
        endcase
    endtask

    // Start one sweep, push the expectation, wait (bounded) for done and score it.
    task automatic run(input int sel, input string name, input logic [31:0] exp_in,
                       input logic [31:0] esig, input logic epass, input int ewc, input int elat);
        exp_t e;
        exp_t g;
        int   t;
        int   n;
        e.name = name; e.sig = esig; e.pass = epass; e.wc = ewc; e.lat = elat;
        exp_q.push_back(e);
        @(negedge clk);
        drive(sel, 1'b1, exp_in);
        t = cyc;
        @(negedge clk);
        drive(sel, 1'b0, exp_in);
        n = 0;
        while (probe(sel, 2) != 32'd1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        g = exp_q.pop_front();
        if (n >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: done never rose", g.name);
        end else begin
            check({g.name, " latency"}, 32'(cyc - t), 32'(g.lat));
            check({g.name, " signature"}, probe(sel, 4), g.sig);
            check({g.name, " pass"}, probe(sel, 3), 32'(g.pass));
            check({g.name, " word_count"}, probe(sel, 5), 32'(g.wc));
        end
    endtask

    initial begin
        logic [31:0] ref_sig;
        int t;
        logic saw_done;

        for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) mem4[i] = '0;
        for (int i = 0; i < 2048; i++) mem2k[i] = 18'((i * 37) ^ (i << 7) ^ 18'h2A5C3);
        mem1 = 18'h3FFFF;

        vecs[0].w = '0;                            vecs[0].exp_in = 32'h0; vecs[0].sig = 32'h0;     vecs[0].pass = 1'b1;
        vecs[1].w = '0; vecs[1].w[0] = 18'h1;      vecs[1].exp_in = 32'h8; vecs[1].sig = 32'h8;     vecs[1].pass = 1'b1;
        vecs[2].w = '0; vecs[2].w[3] = 18'h1;      vecs[2].exp_in = 32'h1; vecs[2].sig = 32'h1;     vecs[2].pass = 1'b1;
        vecs[3].w = '0; vecs[3].w[0] = 18'h1;      vecs[3].exp_in = 32'h9; vecs[3].sig = 32'h8;     vecs[3].pass = 1'b0;
        vecs[4].w = '0; vecs[4].w[0] = 18'h1; vecs[4].w[3] = 18'h1;
                                                   vecs[4].exp_in = 32'h9; vecs[4].sig = 32'h9;     vecs[4].pass = 1'b1;
        vecs[5].w = '0; vecs[5].w[1] = 18'h3FFFF; vecs[5].w[2] = 18'h5;
                                                   vecs[5].exp_in = 32'h0; vecs[5].sig = 32'hFFFF6; vecs[5].pass = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset raddr d%0d", s), probe(s, 0), 32'h0);
            check($sformatf("reset busy d%0d", s), probe(s, 1), 32'h0);
            check($sformatf("reset done d%0d", s), probe(s, 2), 32'h0);
            check($sformatf("reset pass d%0d", s), probe(s, 3), 32'h0);
            check($sformatf("reset sig d%0d", s), probe(s, 4), 32'h0);
            check($sformatf("reset wc d%0d", s), probe(s, 5), 32'h0);
        end

        // Cycle-by-cycle address / busy / done timing of a depth-4 sweep.
        @(negedge clk);
        drive(0, 1'b1, 32'h0);
        t = cyc;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 32'h0);
            check($sformatf("timing raddr t+%0d", k), probe(0, 0), 32'((k - 1 > 3) ? 3 : k - 1));
            check($sformatf("timing busy t+%0d", k), probe(0, 1), 32'(k <= 5));
            check($sformatf("timing done t+%0d", k), probe(0, 2), 32'(k == 6));
        end

        // Table of depth-4 contents.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) mem4[i] = vecs[v].w[i];
            run(0, $sformatf("vec%0d", v), vecs[v].exp_in, vecs[v].sig, vecs[v].pass, 4, 6);
        end

        // start during SWEEP and DRAIN is ignored; a start from DONE restarts.
        for (int i = 0; i < 4; i++) mem4[i] = '0;
        @(negedge clk);
        drive(0, 1'b1, 32'h0);
        t = cyc;
        @(negedge clk); drive(0, 1'b0, 32'h0);
        @(negedge clk); drive(0, 1'b1, 32'h0);
        @(negedge clk); drive(0, 1'b0, 32'h0);
        check("ignore raddr t+3", probe(0, 0), 32'h2);
        @(negedge clk);
        @(negedge clk); drive(0, 1'b1, 32'h0);
        check("ignore busy t+5", probe(0, 1), 32'h1);
        @(negedge clk); drive(0, 1'b0, 32'h0);
        check("ignore done t+6", probe(0, 2), 32'h1);
        check("ignore wc t+6", probe(0, 5), 32'h4);
        @(negedge clk);
        check("ignore stays done", probe(0, 2), 32'h1);
        check("ignore raddr held", probe(0, 0), 32'h3);
        @(negedge clk); drive(0, 1'b1, 32'h0);
        @(negedge clk); drive(0, 1'b0, 32'h0);
        check("restart done", probe(0, 2), 32'h0);
        check("restart raddr", probe(0, 0), 32'h0);
        check("restart busy", probe(0, 1), 32'h1);
        check("restart wc", probe(0, 5), 32'h0);
        repeat (5) @(negedge clk);
        check("restart done again", probe(0, 2), 32'h1);

        // Reset in the middle of a sweep discards everything.
        mem4[0] = 18'h1;
        @(negedge clk);
        drive(0, 1'b1, 32'h0);
        @(negedge clk); drive(0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("midreset sig before", probe(0, 4), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        check("midreset raddr", probe(0, 0), 32'h0);
        check("midreset busy", probe(0, 1), 32'h0);
        check("midreset done", probe(0, 2), 32'h0);
        check("midreset sig", probe(0, 4), 32'h0);
        check("midreset wc", probe(0, 5), 32'h0);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (probe(0, 2) == 32'd1) saw_done = 1'b1;
        end
        check("midreset no done", 32'(saw_done), 32'h0);

        // Depth 1 corner.
        run(2, "depth1", 32'h0003_FFFF, 32'h0003_FFFF, 1'b1, 1, 3);

        // Full 2K sweep against the software model.
        ref_sig = 32'h0;
        for (int i = 0; i < 2048; i++) ref_sig = model_step(ref_sig, 32'(mem2k[i]));
        run(1, "depth2048", ref_sig, ref_sig, 1'b1, 2048, 2050);
        run(1, "depth2048 bad", ref_sig ^ 32'h1, ref_sig, 1'b0, 2048, 2050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
